// File: rtl/cache_refill_arbiter.sv
// Shares one AXI read channel between the icache and dcache refill ports.
// One 4-beat INCR burst per granted miss, one burst outstanding at a time;
// matching beats are packed into the requester's 128-bit line register.
//
// state | meaning
// IDLE  | pick a winner (round-robin on contention), accept its request
// AR    | arvalid high, address/id held until arready
// R     | rready high, store beats with matching rid until rlast
// RET   | one-cycle ret_valid pulse to the granted port
module cache_refill_arbiter #(
  parameter logic [3:0] ICACHE_ID = 4'd0,
  parameter logic [3:0] DCACHE_ID = 4'd1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         icache_rd_req,
  input  logic [31:0]  icache_rd_addr,
  output logic         icache_rd_rdy,
  output logic         icache_ret_valid,
  output logic [127:0] icache_ret_data,
  input  logic         dcache_rd_req,
  input  logic [31:0]  dcache_rd_addr,
  output logic         dcache_rd_rdy,
  output logic         dcache_ret_valid,
  output logic [127:0] dcache_ret_data,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  typedef enum logic [1:0] {IDLE, AR, R, RET} state_t;

  state_t     state;
  logic       last_grant;  // 0: icache, 1: dcache
  logic       grant;       // port owning the current burst, same encoding
  logic [1:0] cnt;
  logic       i_win;
  logic       d_win;

  // Line offset bits of the miss addresses are never needed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{icache_rd_addr[3:0], dcache_rd_addr[3:0]};

  // Winner selection in IDLE: a lone requester wins, contention goes to the
  // port that was not granted last.
  always_comb begin
    i_win = 1'b0;
    d_win = 1'b0;
    if (state == IDLE && !reset) begin
      if (icache_rd_req && dcache_rd_req) begin
        if (last_grant) i_win = 1'b1;
        else            d_win = 1'b1;
      end else if (icache_rd_req) begin
        i_win = 1'b1;
      end else if (dcache_rd_req) begin
        d_win = 1'b1;
      end
    end
  end

  assign icache_rd_rdy = i_win;
  assign dcache_rd_rdy = d_win;

  // Burst sequencing, line assembly and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      last_grant       <= 1'b0;
      grant            <= 1'b0;
      cnt              <= 2'd0;
      arvalid          <= 1'b0;
      rready           <= 1'b0;
      arid             <= 4'd0;
      araddr           <= 32'd0;
      icache_ret_valid <= 1'b0;
      dcache_ret_valid <= 1'b0;
      icache_ret_data  <= 128'd0;
      dcache_ret_data  <= 128'd0;
    end else begin
      icache_ret_valid <= 1'b0;
      dcache_ret_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_win || d_win) begin
            araddr     <= i_win ? {icache_rd_addr[31:4], 4'b0000}
                                : {dcache_rd_addr[31:4], 4'b0000};
            arid       <= i_win ? ICACHE_ID : DCACHE_ID;
            grant      <= d_win;
            last_grant <= d_win;
            cnt        <= 2'd0;
            arvalid    <= 1'b1;
            state      <= AR;
          end
        end
        AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= R;
          end
        end
        R: begin
          // Beats carrying a foreign id are drained but otherwise ignored.
          if (rvalid && rid == arid) begin
            if (grant) dcache_ret_data[{cnt, 5'd0} +: 32] <= rdata;
            else       icache_ret_data[{cnt, 5'd0} +: 32] <= rdata;
            cnt <= cnt + 2'd1;
            if (rlast) begin
              rready <= 1'b0;
              if (grant) dcache_ret_valid <= 1'b1;
              else       icache_ret_valid <= 1'b1;
              state <= RET;
            end
          end
        end
        RET: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Randomised and directed bench for cache_refill_arbiter: an AXI slave model
// pushes the expected line at each AR handshake, a monitor pops on ret_valid.
module tb_cache_refill_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         icache_rd_req, dcache_rd_req;
  logic [31:0]  icache_rd_addr, dcache_rd_addr;
  logic         icache_rd_rdy, dcache_rd_rdy;
  logic         icache_ret_valid, dcache_ret_valid;
  logic [127:0] icache_ret_data, dcache_ret_data;
  logic [3:0]   arid, rid;
  logic [31:0]  araddr, rdata;
  logic         arvalid, arready, rlast, rvalid, rready;

  cache_refill_arbiter dut (
    .clk(clk), .reset(reset),
    .icache_rd_req(icache_rd_req), .icache_rd_addr(icache_rd_addr),
    .icache_rd_rdy(icache_rd_rdy), .icache_ret_valid(icache_ret_valid),
    .icache_ret_data(icache_ret_data),
    .dcache_rd_req(dcache_rd_req), .dcache_rd_addr(dcache_rd_addr),
    .dcache_rd_rdy(dcache_rd_rdy), .dcache_ret_valid(dcache_ret_valid),
    .dcache_ret_data(dcache_ret_data),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  typedef struct { bit port; logic [31:0] addr; } acc_t;
  typedef struct { bit port; logic [127:0] data; } exp_t;

  acc_t         acc_q[$];
  exp_t         exp_q[$];
  logic [127:0] mline [2];
  bit           model_last;
  int           checks = 0, failures = 0;
  int           cyc = 0, ar_hs = 0;
  int           ret_cyc [2];
  bit           prev_ret = 1'b0;

  logic [3:0]  g_rid [16];
  logic [31:0] g_dat [16];
  logic        g_lst [16];
  int          g_nb;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_beat(input int i, input logic [3:0] r, input logic [31:0] d, input logic l);
    g_rid[i] = r; g_dat[i] = d; g_lst[i] = l;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever a line is returned.
  always @(negedge clk) begin
    exp_t e;
    bit   p;
    if (arvalid && arready) ar_hs++;
    if (icache_rd_rdy && dcache_rd_rdy) chk("rdy_exclusive", 2'b11, 2'b01);
    if (icache_ret_valid || dcache_ret_valid) begin
      p = dcache_ret_valid;
      if (icache_ret_valid && dcache_ret_valid) chk("ret_both", 2'b11, 2'b01);
      chk("ret_pulse", prev_ret, 1'b0);
      if (exp_q.size() == 0) begin
        chk("ret_unexpected", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("ret_port", p, e.port);
        chk("ret_data", p ? dcache_ret_data : icache_ret_data, e.data);
      end
      ret_cyc[p] = cyc;
    end
    prev_ret = icache_ret_valid | dcache_ret_valid;
  end

  task automatic do_req(input bit p, input logic [31:0] a, output int acc_cyc);
    bit got = 0;
    bit rdy, other;
    acc_t e;
    acc_cyc = -1;
    @(posedge clk); #1;
    if (p) begin dcache_rd_req = 1'b1; dcache_rd_addr = a; end
    else   begin icache_rd_req = 1'b1; icache_rd_addr = a; end
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      rdy   = p ? dcache_rd_rdy : icache_rd_rdy;
      other = p ? icache_rd_req : dcache_rd_req;
      if (rdy) begin
        if (other) chk("rr_winner", p, !model_last);
        model_last = p;
        e.port = p; e.addr = a;
        acc_q.push_back(e);
        acc_cyc = cyc;
        got = 1;
        break;
      end
    end
    if (!got) chk("req_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    if (p) dcache_rd_req = 1'b0; else icache_rd_req = 1'b0;
  endtask

  // AXI slave: answers one burst, pushing the expected line at the AR handshake.
  task automatic serve(input bit rnd, input int ar_dly, input int abort_after);
    logic [3:0]   br [16];
    logic [31:0]  bd [16];
    logic         bl [16];
    int           nb = 0, nm, c;
    bit           got = 0, p;
    logic [3:0]   gid;
    logic [31:0]  hold_addr;
    logic [127:0] line;
    acc_t         a;
    exp_t         e;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (arvalid) begin got = 1; break; end
    end
    if (!got || acc_q.size() == 0) begin
      chk("ar_timeout", 1'b0, 1'b1);
      return;
    end
    a = acc_q.pop_front();
    p = a.port;
    gid = p ? 4'd1 : 4'd0;
    hold_addr = {a.addr[31:4], 4'b0000};
    chk("araddr", araddr, hold_addr);
    chk("arid", arid, gid);
    if (rnd) begin
      nm = $urandom_range(1, 6);
      for (int m = 0; m < nm; m++) begin
        if ($urandom_range(0, 3) == 0) begin
          br[nb] = gid + 4'($urandom_range(1, 15));
          bd[nb] = $urandom; bl[nb] = 1'($urandom_range(0, 1)); nb++;
        end
        br[nb] = gid; bd[nb] = $urandom; bl[nb] = (m == nm - 1); nb++;
      end
    end else begin
      nb = g_nb;
      for (int i = 0; i < nb; i++) begin br[i] = g_rid[i]; bd[i] = g_dat[i]; bl[i] = g_lst[i]; end
    end
    for (int k = 0; k < ar_dly; k++) begin
      @(negedge clk);
      chk("ar_hold", {arvalid, araddr, arid, icache_rd_rdy, dcache_rd_rdy},
          {1'b1, hold_addr, gid, 2'b00});
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("ar_drop", arvalid, 1'b0);
    if (abort_after == 0) begin
      line = mline[p];
      c = 0;
      for (int i = 0; i < nb; i++)
        if (br[i] == gid) begin line[c*32 +: 32] = bd[i]; c = (c + 1) % 4; end
      mline[p] = line;
      e.port = p; e.data = line;
      exp_q.push_back(e);
    end
    for (int i = 0; i < nb; i++) begin
      if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
      rvalid = 1'b1; rid = br[i]; rdata = bd[i]; rlast = bl[i];
      got = 0;
      for (int t = 0; t < 50; t++) begin
        if (rready) begin got = 1; break; end
        @(negedge clk);
      end
      if (!got) chk("rready_timeout", 1'b0, 1'b1);
      @(negedge clk);
      rvalid = 1'b0; rlast = 1'b0;
      if (abort_after != 0 && i + 1 == abort_after) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_idle", {rready, arvalid}, 2'b00);
        chk("abort_clear", {icache_ret_data, dcache_ret_data}, 256'd0);
        mline[0] = '0; mline[1] = '0; model_last = 1'b0;
        return;
      end
    end
    chk("rready_drop", rready, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ci, cd, d0, d1, hs0, sel, n;
    reset = 1'b1;
    icache_rd_req = 0; dcache_rd_req = 0; icache_rd_addr = 0; dcache_rd_addr = 0;
    arready = 0; rid = 0; rdata = 0; rlast = 0; rvalid = 0;
    mline[0] = '0; mline[1] = '0; model_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {arvalid, rready, icache_rd_rdy, dcache_rd_rdy, icache_ret_valid, dcache_ret_valid}, 6'd0);
    chk("rst_ar", {arid, araddr}, 36'd0);
    chk("rst_data", {icache_ret_data, dcache_ret_data}, 256'd0);
    reset = 1'b0;

    // Single icache miss
    for (int i = 0; i < 4; i++) set_beat(i, 4'd0, 32'hA0 + i, i == 3);
    g_nb = 4;
    fork
      do_req(1'b0, 32'h1FC0_0014, ci);
      serve(1'b0, 0, 0);
    join
    repeat (3) @(negedge clk);
    chk("t1_line", icache_ret_data, 128'h000000A3_000000A2_000000A1_000000A0);

    // Simultaneous pairs: dcache first each time, icache in the IDLE after dcache RET
    for (int pr = 0; pr < 3; pr++) begin
      fork
        do_req(1'b0, $urandom, ci);
        do_req(1'b1, $urandom, cd);
        begin serve(1'b1, 0, 0); serve(1'b1, 0, 0); end
      join
      chk("pair_order", cd < ci, 1'b1);
      chk("pair_gap", ci, ret_cyc[1] + 1);
    end

    // arready held low for 5 cycles
    for (int i = 0; i < 4; i++) set_beat(i, 4'd0, 32'h1000 + i, i == 3);
    g_nb = 4;
    hs0 = ar_hs;
    fork
      do_req(1'b0, 32'h0000_2238, ci);
      serve(1'b0, 5, 0);
    join
    chk("ar_single_hs", ar_hs - hs0, 1);

    // Foreign rid beat between beats 1 and 2
    set_beat(0, 4'd0, 32'hB0, 0); set_beat(1, 4'd0, 32'hB1, 0);
    set_beat(2, 4'd2, 32'hDEAD, 0);
    set_beat(3, 4'd0, 32'hB2, 0); set_beat(4, 4'd0, 32'hB3, 1);
    g_nb = 5;
    fork
      do_req(1'b0, 32'h0000_4000, ci);
      serve(1'b0, 1, 0);
    join
    repeat (3) @(negedge clk);
    chk("rid_skip_line", icache_ret_data, 128'h000000B3_000000B2_000000B1_000000B0);

    // Early rlast after a dcache line of 0x55555555
    for (int i = 0; i < 4; i++) set_beat(i, 4'd1, 32'h5555_5555, i == 3);
    g_nb = 4;
    fork
      do_req(1'b1, 32'h0000_8000, cd);
      serve(1'b0, 0, 0);
    join
    set_beat(0, 4'd1, 32'hC0, 0); set_beat(1, 4'd1, 32'hC1, 1);
    g_nb = 2;
    fork
      do_req(1'b1, 32'h0000_8010, cd);
      serve(1'b0, 0, 0);
    join
    repeat (3) @(negedge clk);
    chk("early_rlast", dcache_ret_data, 128'h55555555_55555555_000000C1_000000C0);

    // Reset during R after two beats, then a fresh request
    for (int i = 0; i < 4; i++) set_beat(i, 4'd0, 32'hE0 + i, i == 3);
    g_nb = 4;
    fork
      do_req(1'b0, 32'h0000_9000, ci);
      serve(1'b0, 0, 2);
    join
    for (int i = 0; i < 4; i++) set_beat(i, 4'd0, 32'hF0 + i, i == 3);
    g_nb = 4;
    fork
      do_req(1'b0, 32'h0000_9100, ci);
      serve(1'b0, 0, 0);
    join

    // Random traffic
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(1, 3);
      n = (sel == 3) ? 2 : 1;
      fork
        begin if (sel[0]) do_req(1'b0, $urandom, d0); end
        begin if (sel[1]) do_req(1'b1, $urandom, d1); end
        begin for (int k = 0; k < n; k++) serve(1'b1, $urandom_range(0, 3), 0); end
      join
    end

    repeat (5) @(negedge clk);
    chk("drain_exp", exp_q.size(), 0);
    chk("drain_acc", acc_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
